// File: rtl/keypad_scan_fifo.sv
// 4x4 matrix keypad scanner: row-at-a-time drive, per-frame debounce FSM,
// and a show-ahead FIFO of 4-bit key codes popped through valid/rd_en.
module keypad_scan_fifo #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int PTR_W          = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       rows,
  input  logic [3:0]       cols,
  input  logic             rd_en,
  output logic [3:0]       key_code,
  output logic             key_valid,
  output logic [PTR_W:0]   fifo_count,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int                 DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]   DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]         DB         = 4'(DEBOUNCE_SCANS);
  localparam logic [PTR_W:0]     FULL_CNT   = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  function automatic logic [1:0] zero_col(input logic [3:0] c);
    zero_col = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!c[i]) zero_col = 2'(i);
  endfunction

  logic [DIV_W-1:0] dwell_cnt;
  logic [1:0]       row_idx;
  logic [3:0]       cols_p0, cols_p1;
  logic             row_last, frame_eval;

  assign row_last   = (dwell_cnt == DWELL_LAST);
  assign frame_eval = row_last && (row_idx == 2'd3);

  // Stage p0/p1: row drive, dwell timing and the two-flop column synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      row_idx   <= 2'd0;
      rows      <= 4'b1110;
      cols_p0   <= 4'b1111;
      cols_p1   <= 4'b1111;
    end else begin
      cols_p0 <= cols;
      cols_p1 <= cols_p0;
      if (row_last) begin
        dwell_cnt <= '0;
        row_idx   <= row_idx + 2'd1;
        rows      <= {rows[2:0], rows[3]};
      end else begin
        dwell_cnt <= dwell_cnt + DIV_W'(1);
      end
    end
  end

  logic       samp_none, samp_single, samp_multi;
  logic [1:0] samp_col;
  logic       frm_bad, frm_hit;
  logic [3:0] frm_key;
  logic       m_bad, m_hit;
  logic [3:0] m_key;
  logic       res_empty, res_single;

  always_comb begin
    samp_none   = (cols_p1 == 4'b1111);
    samp_single = $onehot(~cols_p1);
    samp_multi  = !samp_none && !samp_single;
    samp_col    = zero_col(cols_p1);
    // Merge this row's sample into the frame seen so far
    m_bad      = frm_bad || samp_multi || (frm_hit && samp_single);
    m_hit      = frm_hit || samp_single;
    m_key      = samp_single ? {row_idx, samp_col} : frm_key;
    res_empty  = !m_bad && !m_hit;
    res_single = !m_bad && m_hit;
  end

  // Frame accumulation across rows 0..2; row 3 is merged combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_bad <= 1'b0;
      frm_hit <= 1'b0;
    end else if (row_last) begin
      frm_bad <= frame_eval ? 1'b0 : m_bad;
      frm_hit <= frame_eval ? 1'b0 : m_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (row_last) frm_key <= m_key;
  end

  state_t     state;
  logic [3:0] cand, deb_cnt, rel_cnt;
  logic       push;

  assign push = frame_eval && res_single &&
                (((state == IDLE) && (DB == 4'd1)) ||
                 ((state == DEBOUNCE) && (m_key == cand) && (deb_cnt + 4'd1 == DB)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      deb_cnt <= 4'd0;
      rel_cnt <= 4'd0;
    end else if (frame_eval) begin
      case (state)
        IDLE: if (res_single) begin
          if (DB == 4'd1) state <= HELD;
          else begin
            cand    <= m_key;
            deb_cnt <= 4'd1;
            state   <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!res_single) begin
            state   <= IDLE;
            deb_cnt <= 4'd0;
          end else if (m_key != cand) begin
            cand    <= m_key;
            deb_cnt <= 4'd1;
          end else if (deb_cnt + 4'd1 == DB) begin
            state   <= HELD;
            deb_cnt <= 4'd0;
          end else begin
            deb_cnt <= deb_cnt + 4'd1;
          end
        end
        HELD: if (res_empty) begin
          if (DB == 4'd1) state <= IDLE;
          else begin
            rel_cnt <= 4'd1;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!res_empty) begin
            state   <= HELD;
            rel_cnt <= 4'd0;
          end else if (rel_cnt + 4'd1 == DB) begin
            state   <= IDLE;
            rel_cnt <= 4'd0;
          end else begin
            rel_cnt <= rel_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop, full, wr_ok;

  assign key_valid = (fifo_count != '0);
  assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;
  assign pop       = rd_en && key_valid;
  assign full      = (fifo_count == FULL_CNT);
  // A push into a full FIFO survives only when a pop frees the slot on the same edge
  assign wr_ok     = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= m_key;
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: keypad model on rows/cols, frame-level reference
// model with a queue-based FIFO, per-cycle output comparison plus literal pins.
module tb_keypad_scan_fifo;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int DEPTH    = 4;
  localparam int PTR_W    = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rd_en = 1'b0;
  logic             clr_overflow = 1'b0;
  logic [3:0]       rows, cols, key_code;
  logic             key_valid, overflow;
  logic [PTR_W:0]   fifo_count;
  logic [15:0]      pressed = 16'h0000;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      if (rows[r] == 1'b0) cols = cols & ~pressed[r*4 +: 4];
  end

  keypad_scan_fifo #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(DEPTH), .PTR_W(PTR_W)
  ) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .rd_en(rd_en),
    .key_code(key_code), .key_valid(key_valid), .fifo_count(fifo_count),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;

  // Reference model state (frame-level)
  int m_q[$];
  bit m_ovf;
  int m_phase;
  int m_state;   // 0 idle, 1 debounce, 2 held, 3 release
  int m_cand, m_cnt, m_rel;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_frame(output bit do_push, output int code);
    int nz = 0;
    bit bad = 0;
    int k = 0;
    int kind;
    logic [3:0] nib;
    do_push = 0;
    code = 0;
    for (int r = 0; r < 4; r++) begin
      nib = pressed[r*4 +: 4];
      if ($countones(nib) > 1) bad = 1;
      if (nib != 4'h0) begin
        nz++;
        for (int c = 0; c < 4; c++) if (nib[c]) k = r * 4 + c;
      end
    end
    kind = (bad || nz > 1) ? 2 : (nz == 0) ? 0 : 1;
    case (m_state)
      0: if (kind == 1) begin
        if (DB == 1) begin do_push = 1; code = k; m_state = 2; end
        else begin m_cand = k; m_cnt = 1; m_state = 1; end
      end
      1: if (kind != 1) m_state = 0;
         else if (k != m_cand) begin m_cand = k; m_cnt = 1; end
         else begin
           m_cnt++;
           if (m_cnt == DB) begin do_push = 1; code = k; m_state = 2; end
         end
      2: if (kind == 0) begin
        if (DB == 1) m_state = 0;
        else begin m_rel = 1; m_state = 3; end
      end
      default: if (kind != 0) begin m_state = 2; m_rel = 0; end
               else begin
                 m_rel++;
                 if (m_rel == DB) m_state = 0;
               end
    endcase
  endtask

  task automatic model_step();
    bit do_push = 0;
    int code = 0;
    bit pop, was_full;
    if (rst) begin
      m_q.delete();
      m_ovf = 0; m_phase = 0; m_state = 0; m_cnt = 0; m_rel = 0;
      return;
    end
    if (m_phase == FRAME - 1) model_frame(do_push, code);
    pop = rd_en && (m_q.size() > 0);
    was_full = (m_q.size() == DEPTH);
    if (do_push && was_full && !pop) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
    if (pop) void'(m_q.pop_front());
    if (do_push && (!was_full || pop)) m_q.push_back(code);
    m_phase = (m_phase + 1) % FRAME;
  endtask

  task automatic tick();
    if (rand_mode) begin
      rd_en = ($urandom_range(0, 3) == 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [3:0] er;
    if (chk_en) begin
      er = 4'b1111 ^ (4'b0001 << (m_phase / SCAN_DIV));
      check("rows", int'(rows), int'(er));
      check("key_valid", int'(key_valid), int'(m_q.size() != 0));
      check("fifo_count", int'(fifo_count), m_q.size());
      check("overflow", int'(overflow), int'(m_ovf));
      if (m_q.size() != 0) check("key_code", int'(key_code), m_q[0]);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_frames(input logic [15:0] mask, input int n);
    for (int i = 0; i < FRAME && m_phase != 0; i++) tick();
    pressed = mask;
    repeat (n * FRAME) tick();
  endtask

  task automatic press(input int code);
    run_frames(16'h0001 << code, 2);
    run_frames(16'h0000, 2);
  endtask

  task automatic pop_expect(input int exp, input string name);
    check(name, int'(key_code), exp);
    check({name, "_valid"}, int'(key_valid), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    // 1: reset and scan order
    do_reset();
    check("rst_rows", int'(rows), 4'b1110);
    check("rst_valid", int'(key_valid), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ovf", int'(overflow), 0);
    repeat (4) tick();
    check("rows_r1", int'(rows), 4'b1101);
    repeat (4) tick();
    check("rows_r2", int'(rows), 4'b1011);
    repeat (4) tick();
    check("rows_r3", int'(rows), 4'b0111);
    repeat (4) tick();

    // 2: key 9 held 10 frames, release, re-press
    run_frames(16'h0200, 1);
    check("k9_f1_valid", int'(key_valid), 0);
    run_frames(16'h0200, 1);
    check("k9_f2_valid", int'(key_valid), 1);
    check("k9_f2_code", int'(key_code), 9);
    run_frames(16'h0200, 8);
    check("k9_held_count", int'(fifo_count), 1);
    run_frames(16'h0000, 2);
    run_frames(16'h0200, 2);
    check("k9_repress_count", int'(fifo_count), 2);
    run_frames(16'h0000, 2);
    pop_expect(9, "k9_pop1");
    pop_expect(9, "k9_pop2");
    check("k9_empty", int'(key_valid), 0);

    // 3: bounce
    run_frames(16'h0200, 1);
    run_frames(16'h0000, 3);
    check("bounce_count", int'(fifo_count), 0);
    run_frames(16'h0020, 1);
    run_frames(16'h0040, 2);
    check("k5k6_count", int'(fifo_count), 1);
    check("k5k6_code", int'(key_code), 6);
    run_frames(16'h0000, 2);
    pop_expect(6, "k6_pop");

    // 4: two keys at once
    run_frames(16'h8001, 5);
    check("multi_count", int'(fifo_count), 0);
    check("multi_model_idle", m_state, 0);
    run_frames(16'h0000, 1);

    // 5: overflow
    for (int c = 1; c <= 6; c++) press(c);
    check("ovf_count", int'(fifo_count), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_head", int'(key_code), 1);
    for (int c = 1; c <= 4; c++) pop_expect(c, "ovf_pop");
    check("ovf_drained", int'(key_valid), 0);
    check("ovf_sticky", int'(overflow), 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // 6: rd_en while empty, push+pop while full, reset mid-debounce
    rd_en = 1'b1;
    repeat (20) tick();
    rd_en = 1'b0;
    check("empty_rd_count", int'(fifo_count), 0);
    for (int c = 7; c <= 10; c++) press(c);
    check("full_count", int'(fifo_count), 4);
    run_frames(16'h0800, 1);
    repeat (FRAME - 1) tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pushpop_count", int'(fifo_count), 4);
    check("pushpop_ovf", int'(overflow), 0);
    check("pushpop_head", int'(key_code), 8);
    run_frames(16'h0000, 2);
    for (int c = 8; c <= 11; c++) pop_expect(c, "pushpop_pop");
    press(12);
    press(13);
    check("pre_rst_count", int'(fifo_count), 2);
    run_frames(16'h4000, 1);
    repeat (5) tick();
    pressed = 16'h0000;
    do_reset();
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_valid", int'(key_valid), 0);
    run_frames(16'h0000, 3);
    check("midrst_nopush", int'(fifo_count), 0);

    // Randomized frames with random pops and overflow clears
    rand_mode = 1'b1;
    for (int it = 0; it < 120; it++) begin
      int r;
      logic [15:0] mask;
      r = $urandom_range(0, 9);
      if (r < 2) mask = 16'h0000;
      else if (r < 8) mask = 16'h0001 << $urandom_range(0, 15);
      else mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      run_frames(mask, $urandom_range(1, 4));
    end
    rand_mode = 1'b0;
    rd_en = 1'b0;
    clr_overflow = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
